cntr_prescale: RTL

CNTR_PRESCALE -- requirements
Module: cntr_prescale

---
 rtl/cntr_prescale.sv | 105 ++++++++++
 1 files changed

// File: rtl/cntr_prescale.sv
// Prescaler producing a one-cycle tick every div_reg+1 cycles, with deferred divisor reload.
// Optional sticky overwrite flag `ovr` is compiled in with PRESC_OVR_STATUS_EN.
module cntr_prescale (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] div_val,
    input  logic       div_load,
    output logic       div_ack,
    output logic       tick,
    output logic       busy,
    output logic [3:0] cnt
`ifdef PRESC_OVR_STATUS_EN
    ,
    output logic       ovr
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state;
    logic [3:0] div_reg;
    logic [3:0] pend_val;
    logic       pend_vld;

    logic       at_term;
    logic       commit_vld;
    logic [3:0] commit_val;

    assign at_term    = (cnt == div_reg);
    // A load arriving on a commit edge supersedes anything still pending.
    assign commit_vld = div_load | pend_vld;
    assign commit_val = div_load ? div_val : pend_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            tick     <= 1'b0;
            div_ack  <= 1'b0;
            busy     <= 1'b0;
            div_reg  <= 4'd15;
            pend_val <= 4'd0;
            pend_vld <= 1'b0;
        end else begin
            tick    <= 1'b0;
            div_ack <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    if (div_load) begin
                        div_reg <= div_val;
                        div_ack <= 1'b1;
                    end
                    if (en) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!en) begin
                        // Stop wins over a terminal count: no tick on the way out.
                        state    <= IDLE;
                        busy     <= 1'b0;
                        cnt      <= 4'd0;
                        pend_vld <= 1'b0;
                        if (commit_vld) begin
                            div_reg <= commit_val;
                            div_ack <= 1'b1;
                        end
                    end else if (at_term) begin
                        cnt      <= 4'd0;
                        tick     <= 1'b1;
                        pend_vld <= 1'b0;
                        if (commit_vld) begin
                            div_reg <= commit_val;
                            div_ack <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                        if (div_load) begin
                            pend_val <= div_val;
                            pend_vld <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

`ifdef PRESC_OVR_STATUS_EN
    always_ff @(posedge clk) begin
        if (rst)
            ovr <= 1'b0;
        else if (state == RUN && div_load && pend_vld)
            ovr <= 1'b1;
    end
`endif

endmodule
